// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the PC, drives the synchronous instruction memory and
// presents tagged instructions to decode. Handles decode stalls through a
// one-entry hold buffer. Jump/branch redirects squash the single wrong-path slot.
// Optional build macro FETCH_ALIGN_CHECK_EN adds a sticky misalign_err output.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] imem_addr,
    input  logic [31:0] instruction,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    localparam logic [31:0] ADDR_MASK  = 32'(IMEM_BYTES - 1);
    localparam logic [31:0] ALIGN_MASK = ADDR_MASK & 32'hFFFF_FFFC;

    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        use_hold_q, use_hold_d;

    logic        redirect;
    logic [31:0] raw_target;
    logic [31:0] branch_bytes;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_q, misalign_d;
    assign misalign_err = misalign_q;
`endif

    // Decode-facing view: the hold buffer replaces memory data while a stall is being released.
    always_comb begin
        if_pc       = req_pc_q;
        if_valid    = req_valid_q;
        if_pc_plus4 = (req_pc_q + 32'd4) & ADDR_MASK;
        imem_addr   = pc_q;
        if_instr    = 32'd0;
        if (req_valid_q) begin
            if_instr = use_hold_q ? hold_instr_q : instruction;
        end
    end

    // Redirect selection with jr > jump > branch priority; only a live instruction may redirect.
    always_comb begin
        redirect     = 1'b0;
        raw_target   = 32'd0;
        branch_bytes = {{14{branch_offset[15]}}, branch_offset, 2'b00};
        if (req_valid_q) begin
            if (jr) begin
                redirect   = 1'b1;
                raw_target = jr_addr;
            end else if (jump) begin
                redirect   = 1'b1;
                raw_target = {if_pc_plus4[31:28], jump_target, 2'b00};
            end else if (branch_taken) begin
                redirect   = 1'b1;
                raw_target = if_pc_plus4 + branch_bytes;
            end
        end
    end

    // Next-state: stall freezes the pipe, redirect inserts one bubble, otherwise advance by 4.
    always_comb begin
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        req_valid_d  = req_valid_q;
        hold_instr_d = hold_instr_q;
        use_hold_d   = use_hold_q;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_d   = misalign_q;
`endif
        if (stall) begin
            use_hold_d = 1'b1;
            if (!use_hold_q) begin
                hold_instr_d = instruction;
            end
        end else if (redirect) begin
            pc_d        = raw_target & ALIGN_MASK;
            req_pc_d    = pc_q;
            req_valid_d = 1'b0;
            use_hold_d  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (raw_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
`endif
        end else begin
            pc_d        = (pc_q + 32'd4) & ADDR_MASK;
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
            use_hold_d  = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            req_valid_q  <= 1'b0;
            hold_instr_q <= 32'd0;
            use_hold_q   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            req_valid_q  <= req_valid_d;
            hold_instr_q <= hold_instr_d;
            use_hold_q   <= use_hold_d;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: stream-level reference model feeding a scoreboard queue.
`timescale 1ns/1ps
module tb_fetch_pc_unit;

    localparam int unsigned IMEM_BYTES = 64;
    localparam logic [31:0] MASK       = 32'(IMEM_BYTES - 1);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] plus4;
        logic [31:0] instr;
        logic [31:0] addr;
        logic        merr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] imem_addr;
    logic [31:0] instruction;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    logic [31:0] mem [16];
    exp_t        q[$];
    int          total;
    int          bad;

    // Program-order model: what decode sees now, and the next address in the stream.
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_next;
    bit          m_merr;

    fetch_pc_unit #(.RESET_PC(32'h0), .IMEM_BYTES(IMEM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_target(jump_target), .jr(jr), .jr_addr(jr_addr),
        .imem_addr(imem_addr), .instruction(instruction),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
        .if_valid(if_valid)
`ifdef FETCH_ALIGN_CHECK_EN
        , .misalign_err(misalign_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data for an address appears one edge later.
    always @(posedge clk) instruction <= mem[imem_addr[5:2]];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0;
        m_pc    = 32'h0;
        m_next  = 32'h0;
        m_merr  = 1'b0;
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        e.valid = m_valid;
        e.pc    = m_pc;
        e.plus4 = (m_pc + 32'd4) & MASK;
        e.instr = m_valid ? mem[m_pc[5:2]] : 32'h0;
        e.addr  = m_next;
        e.merr  = m_merr;
        return e;
    endfunction

    function automatic void model_step();
        logic [31:0] plus4;
        logic [31:0] raw;
        int          off_bytes;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (stall) return;
        plus4 = (m_pc + 32'd4) & MASK;
        if (m_valid && (jr || jump || branch_taken)) begin
            if (jr) raw = jr_addr;
            else if (jump) raw = {plus4[31:28], jump_target, 2'b00};
            else begin
                off_bytes = int'($signed(branch_offset)) * 4;
                raw = plus4 + 32'(off_bytes);
            end
            if (raw[1:0] != 2'b00) m_merr = 1'b1;
            m_pc    = m_next;
            m_valid = 1'b0;
            m_next  = raw & MASK & 32'hFFFF_FFFC;
        end else begin
            m_pc    = m_next;
            m_valid = 1'b1;
            m_next  = (m_next + 32'd4) & MASK;
        end
    endfunction

    function automatic void compare(input exp_t e);
        check("if_valid", 32'(if_valid), 32'(e.valid));
        check("if_instr", if_instr, e.instr);
        check("if_pc", if_pc, e.pc);
        check("if_pc_plus4", if_pc_plus4, e.plus4);
        check("imem_addr", imem_addr, e.addr);
`ifdef FETCH_ALIGN_CHECK_EN
        check("misalign_err", 32'(misalign_err), 32'(e.merr));
`endif
    endfunction

    task automatic step(input bit s, input bit br, input logic [15:0] off, input bit j,
                        input logic [25:0] t, input bit r, input logic [31:0] a);
        stall         = s;
        branch_taken  = br;
        branch_offset = off;
        jump          = j;
        jump_target   = t;
        jr            = r;
        jr_addr       = a;
        @(posedge clk);
        model_step();
        q.push_back(model_expect());
        @(negedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per cycle and compares it with what the DUT presents.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                compare(e);
            end
        end
    end

    initial begin
        bit reached;
        bit s;
        bit rd;
        int kind;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        rst_n = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; branch_offset = 16'h0;
        jump = 1'b0; jump_target = 26'h0; jr = 1'b0; jr_addr = 32'h0;
        model_reset();
        q.push_back(model_expect());
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Reset release and sequential fetch up to if_pc = 4.
        step(0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        step(0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        // Three-cycle stall while if_pc = 4, with redirects asserted and ignored.
        step(1, 1, 16'h0010, 0, 26'h0, 0, 32'h0);
        step(1, 0, 16'h0, 1, 26'h5, 0, 32'h0);
        step(1, 0, 16'h0, 0, 26'h0, 1, 32'h30);
        step(0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        step(0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        // Backward branch at if_pc = 12 lands on 8 after one bubble.
        step(0, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0);
        step(0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        // jr beats jump.
        step(0, 1, 16'h0004, 1, 26'h3, 1, 32'h20);
        step(0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        // Run sequentially through pc 60 to the wrap.
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (m_valid && m_pc == 32'd60) reached = 1'b1;
            else step(0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        end
        check("wrap_reached", 32'(reached), 32'd1);
        step(0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        step(0, 0, 16'h0, 0, 26'h0, 0, 32'h0);

        // Random stalls and redirects, including redirects offered while invalid.
        for (int i = 0; i < 400; i++) begin
            s    = ($urandom_range(0, 3) == 0);
            rd   = ($urandom_range(0, 3) == 0);
            kind = int'($urandom_range(1, 7));
            step(s, rd && kind[0], 16'($urandom), rd && kind[1], 26'($urandom),
                 rd && kind[2], $urandom);
        end

        // Asynchronous reset in the middle of a stall.
        step(1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        step(1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare(model_expect());
        step(1, 0, 16'h0, 0, 26'h0, 1, 32'h23);
        rst_n = 1'b1;
        step(0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        // Misaligned register jump: fetch aligned target, flag is sticky.
        step(0, 0, 16'h0, 0, 26'h0, 1, 32'h23);
        for (int i = 0; i < 6; i++) step(0, 0, 16'h0, 0, 26'h0, 0, 32'h0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
